daq_framer: RTL and testbench

Downstream consumer of the DAQ aggregator's packet buffer. Pops one length entry and the matching 32-bit data words, and emits each packet as a framed byte stream toward the MAC transmit path. The frame carries an 8-byte header (magic, sequence number, word count, capture timestamp) followed by the payload words, big-endian, with valid/ready flow control.

---
 rtl/daq_pkg.sv | 34 +++
 rtl/daq_framer.sv | 156 +++++++++++++++
 tb/tb_daq_framer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/daq_pkg.sv
// Shared constants, FSM encoding and header byte layout for the DAQ packet framer.
package daq_pkg;

  localparam logic [7:0]  FRAME_MAGIC = 8'hDA;
  localparam int unsigned HDR_BYTES   = 8;
  localparam int unsigned DF_BITS     = 2;

  typedef enum logic [DF_BITS-1:0] {
    DF_IDLE = 2'd0,
    DF_HDR  = 2'd1,
    DF_DATA = 2'd2
  } df_state_e;

  // Header: magic, seq, len[15:8], len[7:0], ts[31:24..7:0].
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  magic,
                                          input logic [7:0]  seq,
                                          input logic [15:0] len,
                                          input logic [31:0] ts);
    logic [7:0] b;
    case (idx)
      3'd0:    b = magic;
      3'd1:    b = seq;
      3'd2:    b = len[15:8];
      3'd3:    b = len[7:0];
      3'd4:    b = ts[31:24];
      3'd5:    b = ts[23:16];
      3'd6:    b = ts[15:8];
      default: b = ts[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/daq_framer.sv
// Pops length/data entries from the aggregator buffer and streams each packet as a
// big-endian byte frame (8-byte header + payload) with valid/ready flow control.
module daq_framer
  import daq_pkg::*;
#(
  parameter int unsigned MAC_PACKET_BITS = 11,
  parameter logic [7:0]  FRAME_MAGIC     = daq_pkg::FRAME_MAGIC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                systime,
  input  logic [31:0]                daqo_data,
  output logic                       daqo_data_rd_en,
  input  logic [MAC_PACKET_BITS-1:0] daqo_len,
  input  logic                       daqo_len_ready,
  output logic                       daqo_len_rd_en,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic                       tx_last,
  input  logic                       tx_ready
);

  localparam logic [2:0]                 HDR_LAST = 3'(HDR_BYTES - 1);
  localparam logic [MAC_PACKET_BITS-1:0] WORD_ONE = MAC_PACKET_BITS'(1);

  df_state_e                  state_q, state_d;
  logic                       armed_q;
  logic [7:0]                 seq_q, seq_d;
  logic [MAC_PACKET_BITS-1:0] len_q, len_d;
  logic [MAC_PACKET_BITS-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]                ts_q, ts_d;
  logic [31:0]                shift_q, shift_d;
  logic [2:0]                 byte_cnt_q, byte_cnt_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       tx_last_q, tx_last_d;
  logic                       accept;
  logic [15:0]                len_ext;

  assign accept   = tx_valid_q && tx_ready;
  assign len_ext  = 16'(len_q);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    seq_d           = seq_q;
    len_d           = len_q;
    word_cnt_d      = word_cnt_q;
    ts_d            = ts_q;
    shift_d         = shift_q;
    byte_cnt_d      = byte_cnt_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    tx_last_d       = tx_last_q;
    daqo_len_rd_en  = 1'b0;
    daqo_data_rd_en = 1'b0;

    unique case (state_q)
      DF_IDLE: begin
        // armed_q keeps the length FIFO from being popped while reset is asserted.
        if (armed_q && daqo_len_ready) begin
          daqo_len_rd_en = 1'b1;
          len_d          = daqo_len;
          word_cnt_d     = daqo_len;
          ts_d           = systime;
          byte_cnt_d     = '0;
          tx_data_d      = FRAME_MAGIC;
          tx_valid_d     = 1'b1;
          tx_last_d      = 1'b0;
          state_d        = DF_HDR;
        end
      end
      DF_HDR: begin
        if (accept) begin
          if (byte_cnt_q == HDR_LAST) begin
            if (len_q == '0) begin
              seq_d      = seq_q + 8'd1;
              tx_valid_d = 1'b0;
              tx_last_d  = 1'b0;
              state_d    = DF_IDLE;
            end else begin
              daqo_data_rd_en = 1'b1;
              tx_data_d       = daqo_data[31:24];
              shift_d         = {daqo_data[23:0], 8'h00};
              word_cnt_d      = word_cnt_q - WORD_ONE;
              byte_cnt_d      = '0;
              state_d         = DF_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            tx_data_d  = hdr_byte(byte_cnt_d, FRAME_MAGIC, seq_q, len_ext, ts_q);
            tx_last_d  = (byte_cnt_d == HDR_LAST) && (len_q == '0);
          end
        end
      end
      DF_DATA: begin
        if (accept) begin
          if (byte_cnt_q == 3'd3) begin
            if (word_cnt_q != '0) begin
              // Head word is already settled: load it and advance the FIFO together.
              daqo_data_rd_en = 1'b1;
              tx_data_d       = daqo_data[31:24];
              shift_d         = {daqo_data[23:0], 8'h00};
              word_cnt_d      = word_cnt_q - WORD_ONE;
              byte_cnt_d      = '0;
            end else begin
              seq_d      = seq_q + 8'd1;
              tx_valid_d = 1'b0;
              tx_last_d  = 1'b0;
              state_d    = DF_IDLE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            tx_data_d  = shift_q[31:24];
            shift_d    = {shift_q[23:0], 8'h00};
            tx_last_d  = (byte_cnt_q == 3'd2) && (word_cnt_q == '0);
          end
        end
      end
      default: state_d = DF_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DF_IDLE;
      armed_q    <= 1'b0;
      seq_q      <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      ts_q       <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      seq_q      <= seq_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      ts_q       <= ts_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

endmodule

// File: tb/tb_daq_framer.sv
// Scoreboard bench for daq_framer: an aggregator model feeds length/data FIFOs and
// expected frame bytes are queued at stimulus time, then popped on each transfer.
module tb_daq_framer;

  localparam int MPB = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    systime = '0;
  logic           tx_ready = 1'b0;
  logic [31:0]    daqo_data = '0;
  logic [MPB-1:0] daqo_len = '0;
  logic           daqo_len_ready = 1'b0;
  logic           daqo_data_rd_en, daqo_len_rd_en;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_last;

  always #5 clk = ~clk;

  daq_framer #(.MAC_PACKET_BITS(MPB), .FRAME_MAGIC(8'hDA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .systime        (systime),
    .daqo_data      (daqo_data),
    .daqo_data_rd_en(daqo_data_rd_en),
    .daqo_len       (daqo_len),
    .daqo_len_ready (daqo_len_ready),
    .daqo_len_rd_en (daqo_len_rd_en),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .tx_ready       (tx_ready)
  );

  // Aggregator model: FWFT length FIFO, data head visible two cycles after a pop.
  logic [MPB-1:0] lq[$];
  logic [31:0]    dq[$];
  logic [31:0]    d1 = '0;

  always @(posedge clk) begin
    if (daqo_len_rd_en && lq.size() > 0) lq.delete(0);
    if (daqo_data_rd_en && dq.size() > 0) dq.delete(0);
    daqo_len_ready <= (lq.size() != 0);
    daqo_len       <= (lq.size() != 0) ? lq[0] : '0;
    d1             <= (dq.size() != 0) ? dq[0] : 32'hDEAD_BEEF;
    daqo_data      <= d1;
  end

  int passed = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  logic [7:0] exp_seq = '0;

  int  cyc = 0;
  int  frames_done, last_seen, bytes_xfer, data_pops, len_pops, both_pop;
  int  mid_gap, gap_cnt, gap_bad, gaps_checked, frame_idx;
  int  first_valid_cyc, first_len_pop_cyc, pend_len_cyc, min_len_data, last_dpop, min_dgap;
  int  dpop_cyc[$];
  bit  in_frame, seen_frame, stall_pend;
  logic [8:0] held;

  task automatic clear_stats();
    frames_done = 0; last_seen = 0; bytes_xfer = 0; data_pops = 0; len_pops = 0;
    both_pop = 0; mid_gap = 0; gap_cnt = 0; gap_bad = 0; gaps_checked = 0; frame_idx = 0;
    first_valid_cyc = -1; first_len_pop_cyc = -1; pend_len_cyc = -1;
    min_len_data = 1000000; last_dpop = -1; min_dgap = 1000000;
    dpop_cyc.delete(); in_frame = 0; seen_frame = 0; stall_pend = 0;
  endtask

  task automatic queue_frame(input int len, input logic [31:0] words[$], input bit push_data);
    logic [MPB-1:0] lt;
    logic [15:0]    l16;
    logic [31:0]    w;
    lt  = MPB'(len);
    l16 = 16'(lt);
    if (push_data) foreach (words[i]) dq.push_back(words[i]);
    lq.push_back(lt);
    exp_q.push_back({1'b0, 8'hDA});
    exp_q.push_back({1'b0, exp_seq});
    exp_q.push_back({1'b0, l16[15:8]});
    exp_q.push_back({1'b0, l16[7:0]});
    exp_q.push_back({1'b0, systime[31:24]});
    exp_q.push_back({1'b0, systime[23:16]});
    exp_q.push_back({1'b0, systime[15:8]});
    exp_q.push_back({len == 0, systime[7:0]});
    for (int i = 0; i < len; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++)
        exp_q.push_back({(i == len - 1) && (b == 3), w[31 - 8*b -: 8]});
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  // One clock: observe outputs, pick tx_ready, then score the transfer at the next edge.
  task automatic drive_cycle(input int stall_pct);
    logic [8:0] exp;
    @(negedge clk);
    cyc++;
    if (stall_pend) begin
      checks++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, held})
        $display("FAIL stall_hold: got v=%b last=%b data=%h expected v=1 last=%b data=%h",
                 tx_valid, tx_last, tx_data, held[8], held[7:0]);
      else passed++;
    end
    if (tx_valid) begin
      if (!in_frame) begin
        in_frame  = 1;
        frame_idx = 0;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (seen_frame) begin
          gaps_checked++;
          if (gap_cnt != 1) gap_bad++;
        end
      end
    end else if (in_frame) mid_gap++;
    else gap_cnt++;

    tx_ready = ($urandom_range(0, 99) >= stall_pct);
    #1;
    if (daqo_len_rd_en) begin
      len_pops++;
      pend_len_cyc = cyc;
      if (first_len_pop_cyc < 0) first_len_pop_cyc = cyc;
    end
    if (daqo_data_rd_en) begin
      data_pops++;
      dpop_cyc.push_back(cyc);
      if (last_dpop >= 0 && cyc - last_dpop < min_dgap) min_dgap = cyc - last_dpop;
      if (pend_len_cyc >= 0 && cyc - pend_len_cyc < min_len_data) min_len_data = cyc - pend_len_cyc;
      pend_len_cyc = -1;
      last_dpop = cyc;
    end
    if (daqo_len_rd_en && daqo_data_rd_en) both_pop++;

    if (tx_valid && tx_ready) begin
      stall_pend = 0;
      bytes_xfer++;
      frame_idx++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_byte: got data=%h last=%b expected no byte", tx_data, tx_last);
      end else begin
        exp = exp_q.pop_front();
        if ({tx_last, tx_data} !== exp)
          $display("FAIL byte%0d: got data=%h last=%b expected data=%h last=%b",
                   bytes_xfer - 1, tx_data, tx_last, exp[7:0], exp[8]);
        else passed++;
      end
      if (tx_last) begin
        frames_done++;
        last_seen++;
        in_frame   = 0;
        frame_idx  = 0;
        seen_frame = 1;
        gap_cnt    = 0;
      end
    end else if (tx_valid) begin
      stall_pend = 1;
      held = {tx_last, tx_data};
    end else stall_pend = 0;
  endtask

  task automatic run_until(input int n_frames, input int stall_pct, input int budget, input string name);
    int n = 0;
    while (frames_done < n_frames && n < budget) begin
      drive_cycle(stall_pct);
      n++;
    end
    checks++;
    if (frames_done < n_frames)
      $display("FAIL %s_timeout: got %0d frames after %0d cycles, expected %0d", name, frames_done, n, n_frames);
    else passed++;
    tx_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_seq = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); else passed++;
    checks++; if (tx_last !== 1'b0) $display("FAIL rst_tx_last: got %b expected 0", tx_last); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h expected 00", tx_data); else passed++;
    checks++; if (daqo_data_rd_en !== 1'b0) $display("FAIL rst_data_rd: got %b expected 0", daqo_data_rd_en); else passed++;
    checks++; if (daqo_len_rd_en !== 1'b0) $display("FAIL rst_len_rd: got %b expected 0", daqo_len_rd_en); else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, daqo_len_rd_en, daqo_data_rd_en} !== 3'b000)
      $display("FAIL idle_quiet: got v=%b lrd=%b drd=%b expected 000", tx_valid, daqo_len_rd_en, daqo_data_rd_en);
    else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    clear_stats();
    systime = 32'hCAFE_BABE;
    w.push_back(32'h1122_3344);
    w.push_back(32'h5566_7788);
    queue_frame(2, w, 1);
    run_until(1, 0, 200, "basic");
    checks++; if (bytes_xfer != 16) $display("FAIL basic_bytes: got %0d expected 16", bytes_xfer); else passed++;
    checks++; if (last_seen != 1) $display("FAIL basic_last_count: got %0d expected 1", last_seen); else passed++;
    checks++;
    if (dpop_cyc.size() != 2 || dpop_cyc[1] - dpop_cyc[0] != 4)
      $display("FAIL basic_pop_spacing: got %0d pops (spacing %0d) expected 2 pops 4 apart",
               dpop_cyc.size(), (dpop_cyc.size() == 2) ? dpop_cyc[1] - dpop_cyc[0] : -1);
    else passed++;
    checks++;
    if (first_valid_cyc - first_len_pop_cyc != 1)
      $display("FAIL basic_len_to_valid: got %0d cycles expected 1", first_valid_cyc - first_len_pop_cyc);
    else passed++;
    checks++; if (min_len_data < 8) $display("FAIL basic_len_to_data: got %0d expected >=8", min_len_data); else passed++;
    checks++; if (mid_gap != 0) $display("FAIL basic_contiguous: got %0d gaps expected 0", mid_gap); else passed++;
  endtask

  task automatic test_zero_len();
    logic [31:0] w[$];
    clear_stats();
    systime = 32'h0BAD_F00D;
    queue_frame(0, w, 0);
    run_until(1, 0, 100, "zero");
    checks++; if (bytes_xfer != 8) $display("FAIL zero_bytes: got %0d expected 8", bytes_xfer); else passed++;
    checks++; if (data_pops != 0) $display("FAIL zero_data_pops: got %0d expected 0", data_pops); else passed++;
    checks++; if (len_pops != 1) $display("FAIL zero_len_pops: got %0d expected 1", len_pops); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] w[$];
    clear_stats();
    systime = $urandom;
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    queue_frame(5, w, 1);
    run_until(1, 50, 400, "stall");
    checks++; if (data_pops != 5) $display("FAIL stall_data_pops: got %0d expected 5", data_pops); else passed++;
    checks++; if (min_dgap < 4) $display("FAIL stall_pop_gap: got %0d expected >=4", min_dgap); else passed++;
    checks++; if (both_pop != 0) $display("FAIL stall_both_pop: got %0d expected 0", both_pop); else passed++;
    checks++; if (bytes_xfer != 28) $display("FAIL stall_bytes: got %0d expected 28", bytes_xfer); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w[$];
    logic [31:0] rest[$];
    int n = 0;
    clear_stats();
    systime = 32'h1357_9BDF;
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    queue_frame(4, w, 1);
    while (frame_idx < 10 && n < 200) begin
      drive_cycle(0);
      n++;
    end
    @(posedge clk);
    #2;
    checks++; if (tx_valid !== 1'b1) $display("FAIL mid_valid_pre: got %b expected 1", tx_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_last, tx_data, daqo_data_rd_en, daqo_len_rd_en} !== 12'h000)
      $display("FAIL mid_async_reset: got v=%b last=%b data=%h drd=%b lrd=%b expected all 0",
               tx_valid, tx_last, tx_data, daqo_data_rd_en, daqo_len_rd_en);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_seq = '0;
    clear_stats();
    for (int i = 1; i < 4; i++) rest.push_back(w[i]);
    queue_frame(3, rest, 0);
    run_until(1, 0, 200, "after_reset");
    checks++; if (data_pops != 3) $display("FAIL after_reset_pops: got %0d expected 3", data_pops); else passed++;
    checks++; if (last_seen != 1) $display("FAIL after_reset_last: got %0d expected 1", last_seen); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    apply_reset();
    clear_stats();
    systime = 32'h0123_4567;
    for (int f = 0; f < 257; f++) begin
      w.delete();
      for (int i = 0; i < f % 3; i++) w.push_back($urandom);
      queue_frame(f % 3, w, 1);
    end
    run_until(257, 0, 6000, "b2b");
    checks++; if (gaps_checked != 256) $display("FAIL b2b_gaps_seen: got %0d expected 256", gaps_checked); else passed++;
    checks++; if (gap_bad != 0) $display("FAIL b2b_idle_gap: got %0d bad gaps expected 0", gap_bad); else passed++;
    checks++; if (mid_gap != 0) $display("FAIL b2b_contiguous: got %0d expected 0", mid_gap); else passed++;
    checks++; if (both_pop != 0) $display("FAIL b2b_both_pop: got %0d expected 0", both_pop); else passed++;
  endtask

  task automatic test_max_len();
    logic [31:0] w[$];
    clear_stats();
    systime = 32'hFEDC_BA98;
    for (int i = 0; i < 2047; i++) w.push_back($urandom);
    queue_frame(2047, w, 1);
    run_until(1, 0, 9000, "maxlen");
    checks++; if (bytes_xfer != 8196) $display("FAIL maxlen_bytes: got %0d expected 8196", bytes_xfer); else passed++;
    checks++; if (last_seen != 1) $display("FAIL maxlen_last: got %0d expected 1", last_seen); else passed++;
    checks++; if (data_pops != 2047) $display("FAIL maxlen_pops: got %0d expected 2047", data_pops); else passed++;
    checks++; if (min_dgap < 4) $display("FAIL maxlen_pop_gap: got %0d expected >=4", min_dgap); else passed++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_reset_mid_frame();
    test_back_to_back();
    test_max_len();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_bytes: got %0d expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
